// File: rtl/i2c_target_regfile.sv
// -----------------------------------------------------------------------------
// i2c_target_regfile
//
// I2C target (responder) with a byte-wide register file. Decodes START/STOP,
// matches a 7-bit device address, takes a sub-address pointer and then either
// writes data bytes into the register file or returns register contents, with
// the pointer auto-incrementing (and wrapping at NUM_REGS) after every byte.
//
// Parameters:
//   DEV_ADDR  7-bit device address (0x70 -> 0xE0 write / 0xE1 read on the wire)
//   NUM_REGS  number of 8-bit registers; the pointer wraps at NUM_REGS
//   PTR_W     pointer width, 2**PTR_W >= NUM_REGS
//
// Ports:
//   clk        system clock, at least 8x the SCL frequency
//   rst        synchronous active-high reset
//   scl_i      raw SCL from the pad (asynchronous)
//   sda_i      raw SDA from the pad (asynchronous)
//   sda_oe     1 = pull SDA low, 0 = release
//   sda_o      constant 0 (pad value while sda_oe = 1)
//   regs_flat  register file, reg k at bits [8k+7:8k]
//   wr_stb     one-cycle pulse per accepted data byte written
//   wr_addr    register index of the byte in that pulse
//   wr_data    data of the byte in that pulse
//   busy       high from an address-matched START until STOP / NAK / mismatch
//
// Optional build macro:
//   I2C_GLITCH_FILTER_EN  adds a 3-sample agreement filter after the
//                         synchronizers (rejects pulses < 3 clk, +2 clk latency)
// -----------------------------------------------------------------------------
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h70,
  parameter int         NUM_REGS = 12,
  parameter int         PTR_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic                  sda_o,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  wr_stb,
  output logic [PTR_W-1:0]      wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_SUB, S_ACK_S, S_WR, S_ACK_W, S_RD, S_RD_ACK, S_IGNORE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizers (reset to the idle-bus level so
  // that leaving reset never fabricates a START or STOP).
  // ---------------------------------------------------------------------------
  logic [1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s;   // conditioned line values
  logic       scl_p, sda_p;   // previous conditioned values, for edge detect

  always_ff @(posedge clk) begin
    // NOTE: flops are written with non-blocking assignments so every register
    // samples the pre-edge value of its inputs regardless of statement order.
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  // A line value is accepted only once the current and two previous
  // synchronized samples agree; otherwise the last accepted value is held.
  logic [1:0] scl_hist, sda_hist;
  logic       scl_f, sda_f;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    scl_s = scl_f;
    sda_s = sda_f;
    if (scl_sync[1] == scl_hist[0] && scl_hist[0] == scl_hist[1]) scl_s = scl_sync[1];
    if (sda_sync[1] == sda_hist[0] && sda_hist[0] == sda_hist[1]) sda_s = sda_sync[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_f    <= scl_s;
      sda_f    <= sda_s;
    end
  end
`else
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_s;
      sda_p <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  // START/STOP require SCL high on both samples, so they never coincide with
  // an SCL edge and take priority over bit handling.
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

  // ---------------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [3:0]       bit_cnt;     // bits shifted (rx) or driven (tx) in this byte
  logic [7:0]       rx_q;        // receive shift register
  logic [7:0]       tx_q;        // remaining transmit bits, MSB next
  logic [PTR_W-1:0] ptr_q;
  logic [7:0]       regs_q [NUM_REGS];
  logic             sda_oe_d;

  logic             byte_done, addr_match;
  logic [7:0]       rx_next, rd_byte;
  logic [PTR_W-1:0] ptr_inc, ptr_from_sub;

  assign byte_done    = (bit_cnt == 4'd8);
  assign addr_match   = (rx_q[7:1] == DEV_ADDR);
  assign rx_next      = {rx_q[6:0], sda_s};
  assign rd_byte      = regs_q[ptr_q];
  assign ptr_inc      = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_from_sub = PTR_W'(int'(rx_q) % NUM_REGS);

  assign sda_o = 1'b0;

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) regs_flat[8*k +: 8] = regs_q[k];
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. Byte phases end on the falling edge after the 8th
  // bit; acknowledge phases end on the 9th falling edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = S_ADDR;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_ADDR:   if (scl_fall && byte_done) state_d = addr_match ? S_ACK_A : S_IGNORE;
        S_ACK_A:  if (scl_fall) state_d = rx_q[0] ? S_RD : S_SUB;
        S_SUB:    if (scl_fall && byte_done) state_d = S_ACK_S;
        S_ACK_S:  if (scl_fall) state_d = S_WR;
        S_WR:     if (scl_fall && byte_done) state_d = S_ACK_W;
        S_ACK_W:  if (scl_fall) state_d = S_WR;
        S_RD:     if (scl_fall && byte_done) state_d = S_RD_ACK;
        S_RD_ACK: begin
          if (scl_rise && sda_s) state_d = S_IGNORE;   // controller NAK
          else if (scl_fall)     state_d = S_RD;
        end
        default:  state_d = state_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic. SDA only changes in response to an SCL falling edge
  // (registered one clk later), apart from releasing it on START/STOP.
  // ---------------------------------------------------------------------------
  always_comb begin
    sda_oe_d = sda_oe;
    if (start_det || stop_det) begin
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR:           if (scl_fall && byte_done) sda_oe_d = addr_match;
        S_SUB, S_WR:      if (scl_fall && byte_done) sda_oe_d = 1'b1;
        S_ACK_A:          if (scl_fall) sda_oe_d = rx_q[0] ? ~rd_byte[7] : 1'b0;
        S_ACK_S, S_ACK_W: if (scl_fall) sda_oe_d = 1'b0;
        S_RD:             if (scl_fall) sda_oe_d = byte_done ? 1'b0 : ~tx_q[7];
        S_RD_ACK:         if (scl_fall) sda_oe_d = ~rd_byte[7];
        default:          sda_oe_d = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift registers, pointer, register file, write strobe, busy.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is explicitly reset because the core consumes
      // it straight out of reset; this keeps it in flops rather than a RAM.
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      ptr_q   <= '0;
      bit_cnt <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_stb <= 1'b0;
      sda_oe <= sda_oe_d;
      if (start_det) begin
        bit_cnt <= '0;
      end else if (stop_det) begin
        bit_cnt <= '0;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR, S_SUB, S_WR: begin
            if (scl_rise && !byte_done) begin
              rx_q    <= rx_next;
              bit_cnt <= bit_cnt + 4'd1;
              // Commit on the 8th rising edge; a byte cut short never gets here.
              if (state_q == S_WR && bit_cnt == 4'd7) begin
                regs_q[ptr_q] <= rx_next;
                wr_stb        <= 1'b1;
                wr_addr       <= ptr_q;
                wr_data       <= rx_next;
              end
            end
            if (scl_fall && byte_done) begin
              bit_cnt <= '0;
              if (state_q == S_ADDR) busy  <= addr_match;
              if (state_q == S_SUB)  ptr_q <= ptr_from_sub;
            end
          end
          S_ACK_A: begin
            // Read: the MSB goes out with this edge, the rest queue in tx_q.
            if (scl_fall && rx_q[0]) begin
              tx_q    <= {rd_byte[6:0], 1'b0};
              bit_cnt <= 4'd1;
            end
          end
          S_ACK_W: begin
            if (scl_fall) ptr_q <= ptr_inc;
          end
          S_RD: begin
            if (scl_fall) begin
              if (byte_done) begin
                bit_cnt <= '0;
              end else begin
                tx_q    <= {tx_q[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) busy  <= 1'b0;
              else       ptr_q <= ptr_inc;
            end
            if (scl_fall) begin
              tx_q    <= {rd_byte[6:0], 1'b0};
              bit_cnt <= 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// -----------------------------------------------------------------------------
// tb_i2c_target_regfile
//
// Bit-banged I2C controller driving i2c_target_regfile over an open-drain SDA
// model. A behavioural register-file model predicts every ACK, write strobe
// and read byte; write strobes and read bytes are queued as expectations and
// compared by a separate monitor process.
// -----------------------------------------------------------------------------
module tb_i2c_target_regfile;

  localparam int NUM_REGS = 12;
  localparam int PTR_W    = 4;
  localparam int TQ       = 6;   // clk from SCL fall to SDA change, and SDA change to SCL rise
  localparam int TH       = 8;   // clk SCL stays high

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  scl_m, sda_m;
  logic                  sda_line;
  logic                  sda_oe, sda_o, wr_stb, busy;
  logic [8*NUM_REGS-1:0] regs_flat;
  logic [PTR_W-1:0]      wr_addr;
  logic [7:0]            wr_data;

  // Wired-AND bus: the target only ever pulls low.
  assign sda_line = sda_m & (sda_oe ? sda_o : 1'b1);

  always #5 clk = ~clk;

  i2c_target_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .sda_o     (sda_o),
    .regs_flat (regs_flat),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  // Reference model and scoreboard queues
  logic [7:0]  m_regs [NUM_REGS];
  int          m_ptr;
  logic [11:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  obs_rd [$];
  logic [7:0]  dq [$];

  int checks   = 0;
  int failures = 0;
  bit watch_nodrive = 0;
  bit saw_drive     = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8*NUM_REGS-1:0] model_flat();
    logic [8*NUM_REGS-1:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[8*k +: 8] = m_regs[k];
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- bus primitives (entered/left with SCL low) ---------------
  task automatic bus_bit(input logic b, output logic s);
    tick(TQ); sda_m = b;
    tick(TQ); scl_m = 1'b1;
    tick(TH/2); s = sda_line;
    tick(TH/2); scl_m = 1'b0;
  endtask

  task automatic bus_start();
    if (scl_m == 1'b0) begin
      tick(TQ); sda_m = 1'b1;
      tick(TQ); scl_m = 1'b1;
    end
    tick(TH); sda_m = 1'b0;
    tick(TH); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    tick(TQ); sda_m = 1'b0;
    tick(TQ); scl_m = 1'b1;
    tick(TH); sda_m = 1'b1;
    tick(TH);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic give_ack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, s);
      d = {d[6:0], s};
    end
    bus_bit(~give_ack, s);
  endtask

  // ---------------- transactions with model update ----------------
  task automatic write_txn(input logic [7:0] addr_byte, input logic [7:0] sub,
                           input logic [7:0] data [$]);
    logic ack;
    logic match;
    match = (addr_byte[7:1] == 7'h70);
    bus_start();
    send_byte(addr_byte, ack);
    check("addr_ack", 128'(ack), 128'(match));
    check("busy_after_addr", 128'(busy), 128'(match));
    send_byte(sub, ack);
    check("sub_ack", 128'(ack), 128'(match));
    if (match) m_ptr = sub % NUM_REGS;
    foreach (data[i]) begin
      if (match) begin
        exp_wr.push_back({PTR_W'(m_ptr), data[i]});
        m_regs[m_ptr] = data[i];
        m_ptr = (m_ptr + 1) % NUM_REGS;
      end
      send_byte(data[i], ack);
      check("data_ack", 128'(ack), 128'(match));
    end
    bus_stop();
    check("busy_after_stop", 128'(busy), 128'(0));
    check("sda_oe_after_stop", 128'(sda_oe), 128'(0));
    check("regs_after_write", 128'(regs_flat), 128'(model_flat()));
  endtask

  task automatic read_txn(input bit use_sub, input logic [7:0] sub, input int n);
    logic       ack;
    logic [7:0] d;
    bus_start();
    if (use_sub) begin
      send_byte(8'hE0, ack);
      check("rd_waddr_ack", 128'(ack), 128'(1));
      send_byte(sub, ack);
      check("rd_sub_ack", 128'(ack), 128'(1));
      m_ptr = sub % NUM_REGS;
      bus_start();
    end
    send_byte(8'hE1, ack);
    check("rd_addr_ack", 128'(ack), 128'(1));
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(m_regs[m_ptr]);
      recv_byte(i != n - 1, d);
      obs_rd.push_back(d);
      if (i != n - 1) m_ptr = (m_ptr + 1) % NUM_REGS;
    end
    bus_stop();
    check("rd_busy_after_stop", 128'(busy), 128'(0));
    check("rd_sda_oe_after_stop", 128'(sda_oe), 128'(0));
  endtask

`ifdef I2C_GLITCH_FILTER_EN
  // A data bit with a 1-clk spurious SCL pulse while SCL is low.
  task automatic bus_bit_glitch(input logic b);
    tick(TQ); sda_m = b;
    tick(2);  scl_m = 1'b1;
    tick(1);  scl_m = 1'b0;
    tick(TQ - 3); scl_m = 1'b1;
    tick(TH); scl_m = 1'b0;
  endtask
`endif

  // ---------------- monitor: pops expectations as outputs appear ----------------
  always @(negedge clk) begin
    logic [11:0] e;
    logic [7:0]  o, x;
    if (!rst && wr_stb) begin
      if (exp_wr.size() == 0) begin
        check("wr_stb_spurious", 128'(wr_stb), 128'(0));
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", 128'(wr_addr), 128'(e[11:8]));
        check("wr_data", 128'(wr_data), 128'(e[7:0]));
      end
    end
    while (obs_rd.size() > 0 && exp_rd.size() > 0) begin
      o = obs_rd.pop_front();
      x = exp_rd.pop_front();
      check("rd_data", 128'(o), 128'(x));
    end
    if (watch_nodrive && sda_oe) saw_drive = 1'b1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic       s, ack;
    logic [7:0] ab, d;
    int         kind, n;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
    m_ptr = 0;
    tick(5);
    rst = 1'b0;
    tick(5);
    check("reset_sda_oe",  128'(sda_oe), 128'(0));
    check("reset_sda_o",   128'(sda_o), 128'(0));
    check("reset_busy",    128'(busy), 128'(0));
    check("reset_wr_stb",  128'(wr_stb), 128'(0));
    check("reset_wr_addr", 128'(wr_addr), 128'(0));
    check("reset_wr_data", 128'(wr_data), 128'(0));
    check("reset_regs",    128'(regs_flat), 128'(0));

    // Basic write, then pointer continuation read (ptr should be 2)
    dq = {8'hAA, 8'h55};
    write_txn(8'hE0, 8'h00, dq);
    read_txn(1'b0, 8'h00, 1);

    // Fill, then full read with wrap (12 ACKed + 1 NAKed byte)
    dq = {8'h69, 8'h96, 8'h01, 8'h02, 8'h03, 8'h04};
    write_txn(8'hE0, 8'h02, dq);
    dq = {8'h2B, 8'hFF};
    write_txn(8'hE0, 8'h08, dq);
    read_txn(1'b1, 8'h00, 13);

    // Foreign address: never driven, no writes, busy low
    saw_drive = 1'b0;
    watch_nodrive = 1'b1;
    dq = {8'h12, 8'h34};
    write_txn(8'hE2, 8'h01, dq);
    watch_nodrive = 1'b0;
    check("foreign_no_drive", 128'(saw_drive), 128'(0));

    // Pointer wrap on write, sub-address wrap (0x0F -> 3)
    dq = {8'h11, 8'h22};
    write_txn(8'hE0, 8'h0B, dq);
    dq = {};
    write_txn(8'hE0, 8'h0F, dq);
    read_txn(1'b0, 8'h00, 2);

    // STOP after 4 bits of a data byte
    bus_start();
    send_byte(8'hE0, ack);
    check("partial_addr_ack", 128'(ack), 128'(1));
    send_byte(8'h05, ack);
    check("partial_sub_ack", 128'(ack), 128'(1));
    m_ptr = 5;
    for (int i = 0; i < 4; i++) bus_bit(1'(i & 1), s);
    bus_stop();
    check("partial_busy", 128'(busy), 128'(0));
    check("partial_sda_oe", 128'(sda_oe), 128'(0));
    check("partial_regs", 128'(regs_flat), 128'(model_flat()));
    read_txn(1'b0, 8'h00, 1);

    // Randomized transactions against the model
    for (int t = 0; t < 24; t++) begin
      kind = int'($urandom_range(0, 3));
      dq = {};
      case (kind)
        0: begin
          n = int'($urandom_range(0, 3));
          for (int i = 0; i < n; i++) dq.push_back(8'($urandom_range(0, 255)));
          write_txn(8'hE0, 8'($urandom_range(0, 255)), dq);
        end
        1: read_txn(1'b1, 8'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
        2: read_txn(1'b0, 8'h00, int'($urandom_range(1, 3)));
        default: begin
          ab = {7'($urandom_range(0, 127)), 1'b0};
          dq.push_back(8'($urandom_range(0, 255)));
          write_txn(ab, 8'($urandom_range(0, 255)), dq);
        end
      endcase
    end

`ifdef I2C_GLITCH_FILTER_EN
    // 1-clk SCL glitches inside every bit of a data byte
    bus_start();
    send_byte(8'hE0, ack);
    check("glitch_addr_ack", 128'(ack), 128'(1));
    send_byte(8'h06, ack);
    check("glitch_sub_ack", 128'(ack), 128'(1));
    d = 8'hC3;
    exp_wr.push_back({PTR_W'(6), d});
    m_regs[6] = d;
    m_ptr = 7;
    for (int i = 7; i >= 0; i--) bus_bit_glitch(d[i]);
    bus_bit(1'b1, s);
    check("glitch_data_ack", 128'(~s), 128'(1));
    bus_stop();
    check("glitch_regs", 128'(regs_flat), 128'(model_flat()));
`endif

    // Reset while the target is driving the address ACK
    ab = 8'hE0;
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(ab[i], s);
    tick(TQ);
    check("ack_driven_before_rst", 128'(sda_oe), 128'(1));
    rst = 1'b1;
    tick(1);
    check("rst_sda_oe", 128'(sda_oe), 128'(0));
    check("rst_regs", 128'(regs_flat), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
    m_ptr = 0;
    sda_m = 1'b1;
    tick(TQ);
    scl_m = 1'b1;
    tick(20);
    read_txn(1'b0, 8'h00, 2);
    dq = {8'h5A};
    write_txn(8'hE0, 8'h04, dq);

    tick(20);
    check("wr_queue_drained", 128'(exp_wr.size()), 128'(0));
    check("rd_queue_drained", 128'(exp_rd.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
